// File: rtl/rr_grant_pkg.sv
// rtl/rr_grant_pkg.sv - shared state encoding and scan chain layout for rr_grant_ctrl
package rr_grant_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_COOL    = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

  // Chain order MSB-first: state, ptr, id, cnt.
  localparam int SCAN_STATE_W = 2;
  localparam int SCAN_IDX_FIELDS = 2;

  function automatic int scan_len(input int idw, input int cw);
    return SCAN_STATE_W + SCAN_IDX_FIELDS * idw + cw;
  endfunction

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// rtl/rr_grant_ctrl_if.sv - request/grant bundle between requesters and rr_grant_ctrl
interface rr_grant_ctrl_if #(
  parameter int NCH = 4
);
  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           en;
  logic [NCH-1:0] req;
  logic [NCH-1:0] done;
  logic [NCH-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  modport master (output en, req, done, input gnt, gnt_id, busy, timeout);
  modport slave  (input en, req, done, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-priority selector: first set request at or after ptr, wrapping
module rr_pick #(
  parameter int NCH = 4,
  parameter int IDW = 2
) (
  input  logic [NCH-1:0] i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic           o_valid,
  output logic [IDW-1:0] o_idx
);
  logic [NCH-1:0] w_rot;
  logic [IDW:0]   w_sum;

  assign o_valid = |i_req;
  assign w_rot   = NCH'({i_req, i_req} >> i_ptr);

  // Walk downward so the lowest rotated position (closest to ptr) wins.
  always_comb begin
    o_idx = '0;
    w_sum = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
        if (w_sum >= (IDW+1)'(NCH)) w_sum = w_sum - (IDW+1)'(NCH);
        o_idx = w_sum[IDW-1:0];
      end
    end
  end
endmodule

// File: rtl/rr_grant_ctrl.sv
// rtl/rr_grant_ctrl.sv - round-robin grant FSM with bounded hold, functional clear and scan chain
module rr_grant_ctrl
  import rr_grant_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_scan_en,
  input  logic             i_scan_in,
  output logic             o_scan_out,
  rr_grant_ctrl_if.slave   bus
);
  localparam int IDW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW       = $clog2(HOLD_MAX);
  localparam int SCAN_LEN = scan_len(IDW, CW);

  state_e         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [CW-1:0]  r_cnt;
  logic           r_timeout;

  logic                w_valid;
  logic [IDW-1:0]      w_idx;
  logic [SCAN_LEN-1:0] w_chain;
  logic [SCAN_LEN-1:0] w_chain_nxt;
  logic                w_granting;

  rr_pick #(.NCH(NCH), .IDW(IDW)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_chain     = {r_state, r_ptr, r_id, r_cnt};
  assign w_chain_nxt = {w_chain[SCAN_LEN-2:0], i_scan_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (i_scan_en) begin
      r_state   <= state_e'(w_chain_nxt[SCAN_LEN-1 -: SCAN_STATE_W]);
      r_ptr     <= w_chain_nxt[CW+IDW +: IDW];
      r_id      <= w_chain_nxt[CW +: IDW];
      r_cnt     <= w_chain_nxt[CW-1:0];
      r_timeout <= 1'b0;
    end else if (i_clr) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.en && w_valid) begin
            r_id    <= w_idx;
            r_cnt   <= '0;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A normal release outranks the hold limit on the same cycle.
          if (bus.done[r_id] || !bus.req[r_id]) begin
            r_state <= ST_COOL;
          end else if (r_cnt == CW'(HOLD_MAX - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= ST_COOL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_COOL: begin
          r_ptr   <= (r_id >= IDW'(NCH - 1)) ? '0 : r_id + 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_granting  = (r_state == ST_GRANT) && !i_scan_en;
  assign bus.gnt     = w_granting ? (NCH'(1) << r_id) : '0;
  assign bus.busy    = w_granting;
  assign bus.gnt_id  = r_id;
  assign bus.timeout = r_timeout && !i_scan_en;
  assign o_scan_out  = w_chain[SCAN_LEN-1];
endmodule
